// File: rtl/tick_timer.sv
// tick_timer: programmable down-counter advanced by prescaler ticks.
// Loads a start value, decrements once per tick, and can be paused,
// resumed and cleared. Expiry gives a one-cycle done pulse and a sticky
// expired flag. All outputs are decoded from registers.
module tick_timer #(
  parameter int N = 4
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         i_tick,
  input  logic [N-1:0] i_load_val,
  input  logic         i_start,
  input  logic         i_stop,
  input  logic         i_clear,
  output logic [N-1:0] o_count,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_expired
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] count_q, count_d;
  logic         done_q, done_d;

  // State, count and done-pulse registers with asynchronous reset.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; command priority is clear > stop > start > tick.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = 1'b0;
    if (i_clear) begin
      // Abort without a done pulse.
      state_d = IDLE;
      count_d = '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          // Stop has no meaning here, so start acts even when stop is high.
          if (i_start) begin
            count_d = i_load_val;
            if (i_load_val == '0) begin
              // Zero-length timer expires immediately.
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              state_d = RUN;
            end
          end
        end
        RUN: begin
          // Start is ignored while running; a tick coincident with stop is dropped.
          if (i_stop) begin
            state_d = PAUSED;
          end else if (i_tick) begin
            count_d = count_q - N'(1);
            if (count_q == N'(1)) begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end
        end
        PAUSED: begin
          // Resume keeps the held count; the load value is not sampled.
          if (!i_stop && i_start) begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  assign o_count   = count_q;
  assign o_busy    = (state_q == RUN) || (state_q == PAUSED);
  assign o_done    = done_q;
  assign o_expired = (state_q == DONE);

endmodule

// File: tb/tb_tick_timer.sv
// Directed testbench for tick_timer with hand-computed expectations.
module tb_tick_timer;

  localparam int N = 4;

  logic         clk;
  logic         reset_n;
  logic         tick;
  logic [N-1:0] load_val;
  logic         start;
  logic         stop;
  logic         clear;
  logic [N-1:0] count;
  logic         busy;
  logic         done;
  logic         expired;

  int n_checks;
  int n_pass;

  tick_timer #(.N(N)) dut (
    .i_clk      (clk),
    .i_reset_n  (reset_n),
    .i_tick     (tick),
    .i_load_val (load_val),
    .i_start    (start),
    .i_stop     (stop),
    .i_clear    (clear),
    .o_count    (count),
    .o_busy     (busy),
    .o_done     (done),
    .o_expired  (expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    tick = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
  endtask

  task automatic check_out(input string tag, input int c, input int b,
                           input int d, input int e);
    check({tag, ".count"},   int'(count),   c);
    check({tag, ".busy"},    int'(busy),    b);
    check({tag, ".done"},    int'(done),    d);
    check({tag, ".expired"}, int'(expired), e);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset_n  = 1'b0;
    load_val = '0;
    idle_inputs();
    #2;
    check_out("reset", 0, 0, 0, 0);
    step();
    step();
    reset_n = 1'b1;
    step();
    check_out("idle", 0, 0, 0, 0);

    // Load 3, tick every cycle: 3,2,1,0 with one done pulse.
    load_val = 4'd3; start = 1'b1;
    step();
    start = 1'b0; load_val = 4'd7;
    check_out("l3.start", 3, 1, 0, 0);
    tick = 1'b1;
    step(); check_out("l3.t1", 2, 1, 0, 0);
    step(); check_out("l3.t2", 1, 1, 0, 0);
    step(); check_out("l3.t3", 0, 0, 1, 1);
    step(); check_out("l3.after", 0, 0, 0, 1);
    step(); check_out("l3.sticky", 0, 0, 0, 1);
    tick = 1'b0;

    // Clear to IDLE, then load 5 with a tick every 4th cycle; pause on 2nd tick.
    clear = 1'b1;
    step();
    clear = 1'b0;
    check_out("clr", 0, 0, 0, 0);
    load_val = 4'd5; start = 1'b1;
    step();
    start = 1'b0;
    check_out("l5.start", 5, 1, 0, 0);
    for (int t = 1; t <= 2; t++) begin
      for (int k = 0; k < 3; k++) step();
      tick = 1'b1;
      if (t == 2) stop = 1'b1;
      step();
      tick = 1'b0; stop = 1'b0;
    end
    check_out("l5.paused", 4, 1, 0, 0);
    tick = 1'b1;
    for (int k = 0; k < 10; k++) step();
    check_out("l5.hold", 4, 1, 0, 0);
    tick = 1'b0; start = 1'b1; load_val = 4'd12;
    step();
    start = 1'b0;
    check_out("l5.resume", 4, 1, 0, 0);
    tick = 1'b1;
    step(); check("l5.r1", int'(count), 3);
    step(); check("l5.r2", int'(count), 2);
    step(); check("l5.r3", int'(count), 1);
    step(); check_out("l5.r4", 0, 0, 1, 1);
    tick = 1'b0;

    // Zero-length timer from IDLE.
    clear = 1'b1;
    step();
    clear = 1'b0;
    load_val = 4'd0; start = 1'b1;
    step();
    start = 1'b0;
    check_out("l0", 0, 0, 1, 1);
    step();
    check_out("l0.after", 0, 0, 0, 1);

    // Restart from DONE with the maximum value; no wrap.
    load_val = 4'd15; start = 1'b1;
    step();
    start = 1'b0;
    check_out("l15.start", 15, 1, 0, 0);
    tick = 1'b1;
    for (int k = 0; k < 14; k++) step();
    check_out("l15.t14", 1, 1, 0, 0);
    step();
    check_out("l15.t15", 0, 0, 1, 1);
    step();
    check_out("l15.t16", 0, 0, 0, 1);
    tick = 1'b0;

    // All commands at once in RUN with count 1: clear wins, no done pulse.
    load_val = 4'd1; start = 1'b1;
    step();
    start = 1'b0;
    check_out("all.start", 1, 1, 0, 0);
    clear = 1'b1; stop = 1'b1; start = 1'b1; tick = 1'b1;
    step();
    idle_inputs();
    check_out("all", 0, 0, 0, 0);
    step();
    check_out("all.after", 0, 0, 0, 0);

    // Asynchronous reset mid-RUN.
    load_val = 4'd9; start = 1'b1;
    step();
    start = 1'b0;
    tick = 1'b1;
    step(); step(); step();
    tick = 1'b0;
    check_out("rst.pre", 6, 1, 0, 0);
    #1;
    reset_n = 1'b0;
    #1;
    check_out("rst.async", 0, 0, 0, 0);
    #1;
    reset_n = 1'b1;
    tick = 1'b1;
    step();
    tick = 1'b0;
    check_out("rst.tick", 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
